// File: rtl/branch_redirect.sv
// Branch resolution and PC redirect controller.
// Evaluates the branch condition in EX, computes the redirect target, issues a
// redirect to the PC unit and then holds flush high while the squash completes.
// It also keeps saturating counters of accepted and taken branches.
module branch_redirect #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic [2:0]       br_type,
  input  logic [1:0]       zero,
  input  logic [31:0]      pc_plus4,
  input  logic [31:0]      imm,
  input  logic             pc_ack,
  output logic             busy,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  // Branch type encodings
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b101;
  localparam logic [2:0] BR_BGEZ = 3'b110;
  localparam logic [2:0] BR_J    = 3'b111;

  // Comparator result encodings
  localparam logic [1:0] CMP_EQUAL = 2'b01;
  localparam logic [1:0] CMP_LT    = 2'b10;
  localparam logic [1:0] CMP_GT    = 2'b11;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [3:0]  flush_cnt;
  logic        taken;
  logic        accept;
  logic [31:0] target;

  // Branch condition decode; DEFAULT comparator code never matches any case.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    taken = 1'b0;
    case (br_type)
      BR_BEQ:  taken = (zero == CMP_EQUAL);
      BR_BNE:  taken = (zero == CMP_LT) || (zero == CMP_GT);
      BR_BLEZ: taken = (zero == CMP_EQUAL) || (zero == CMP_LT);
      BR_BGTZ: taken = (zero == CMP_GT);
      BR_BLTZ: taken = (zero == CMP_LT);
      BR_BGEZ: taken = (zero == CMP_EQUAL) || (zero == CMP_GT);
      BR_J:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // A branch is only considered while idle; anything presented while busy is dropped.
  assign accept = (state == IDLE) && br_valid && (br_type != BR_NONE);

  // Word offset added to PC+4; wraps silently modulo 2^32.
  assign target = pc_plus4 + (imm << 2);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: one transition per edge, FLUSH is never skipped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept && taken)      state_next = REDIRECT;
      REDIRECT: if (pc_ack)               state_next = FLUSH;
      FLUSH:    if (flush_cnt <= 4'd1)    state_next = IDLE;
      default:                            state_next = IDLE;
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    redirect_valid = (state == REDIRECT);
    flush          = (state != IDLE);
    busy           = (state != IDLE);
  end

  // Flush counter: loaded when the PC unit accepts, counts down through FLUSH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= 4'd0;
    end else if (state == REDIRECT && pc_ack) begin
      flush_cnt <= FLUSH_LOAD;
    end else if (state == FLUSH && flush_cnt != 4'd0) begin
      flush_cnt <= flush_cnt - 4'd1;
    end
  end

  // Capture the target when a taken branch is accepted; held until the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                redirect_pc <= 32'd0;
    else if (accept && taken)  redirect_pc <= target;
  end

  // Saturating branch statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (accept) begin
      if (branch_cnt != '1)        branch_cnt <= branch_cnt + CNT_W'(1);
      if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
